// File: rtl/dump_pkg.sv
// Shared types and default widths for the register-file dump unit.
package dump_pkg;

  localparam int DEF_NB_DATA    = 32;
  localparam int DEF_NB_BYTE    = 8;
  localparam int BYTES_PER_WORD = DEF_NB_DATA / DEF_NB_BYTE;
  localparam int NB_BYTE_CNT    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Loads one register word and emits it MSB-byte-first over a valid/ready byte stream.
module word_byte_serializer
  import dump_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_BYTE = DEF_NB_BYTE,
  parameter int BPW     = BYTES_PER_WORD,
  parameter int NB_CNT  = NB_BYTE_CNT
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_abort,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_last_accepted
);

  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BPW - 1);

  logic [NB_DATA-1:0] shift_reg;
  logic [NB_CNT-1:0]  cnt_reg;
  logic               valid_reg;
  logic               accept;

  assign accept          = valid_reg & i_tx_ready;
  assign o_last_accepted = accept && (cnt_reg == LAST_BYTE);
  assign o_tx_data       = shift_reg[NB_DATA-1 -: NB_BYTE];
  assign o_tx_valid      = valid_reg;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (i_abort) begin
      valid_reg <= 1'b0;
    end else if (i_load) begin
      shift_reg <= i_word;
      cnt_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (accept) begin
      // Shifting on every accept keeps the next byte at the top with no mux.
      shift_reg <= shift_reg << NB_BYTE;
      cnt_reg   <= cnt_reg + 1'b1;
      if (cnt_reg == LAST_BYTE) valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_unit.sv
// Walks the register file read port and streams every word out as bytes for the debug UART.
module regfile_dump_unit
  import dump_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32,
  parameter int NB_BYTE = DEF_NB_BYTE
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0] i_rd_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BPW    = NB_DATA / NB_BYTE;
  localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_ADDR-1:0] LAST_INDEX = NB_ADDR'(N_REGS - 1);

  state_t             state_reg, state_next;
  logic [NB_ADDR-1:0] index_reg, index_next;
  logic               load;
  logic               last_accepted;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    if (i_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            index_next = '0;
            state_next = ST_ADDR;
          end
        end
        ST_ADDR:  state_next = ST_LATCH;
        ST_LATCH: state_next = ST_SEND;
        ST_SEND: begin
          if (last_accepted) begin
            if (index_reg == LAST_INDEX) begin
              state_next = ST_DONE;
            end else begin
              index_next = index_reg + 1'b1;
              state_next = ST_ADDR;
            end
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Read data is valid in LATCH because the register file has one cycle of latency.
  assign load      = (state_reg == ST_LATCH) && !i_abort;
  assign o_rd_addr = (state_reg == ST_IDLE) ? '0 : index_reg;
  assign o_busy    = (state_reg != ST_IDLE);
  assign o_done    = (state_reg == ST_DONE);

  word_byte_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE),
    .BPW     (BPW),
    .NB_CNT  (NB_CNT)
  ) u_serializer (
    .clk             (clk),
    .i_rst_n         (i_rst_n),
    .i_load          (load),
    .i_word          (i_rd_data),
    .i_abort         (i_abort),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_ready      (i_tx_ready),
    .o_last_accepted (last_accepted)
  );

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed and randomized bench for regfile_dump_unit against a byte-stream reference model.
module tb_regfile_dump_unit;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int N_REGS  = 32;
  localparam int NB_BYTE = 8;
  localparam int BPW     = NB_DATA / NB_BYTE;

  logic               clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic               i_abort = 1'b0;
  logic               i_tx_ready = 1'b0;
  logic [NB_ADDR-1:0] o_rd_addr;
  logic [NB_DATA-1:0] i_rd_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               o_busy;
  logic               o_done;

  logic [NB_DATA-1:0] regs [N_REGS];
  logic [7:0]         exp_q[$];
  logic [7:0]         got_q[$];
  int                 addr_q[$];
  int                 done_cnt;
  int                 done_cyc;
  int                 busy_fall_cyc;
  logic               prev_busy = 1'b0;
  int                 cyc = 0;
  int                 n_assert = 0;
  int                 n_fail = 0;

  regfile_dump_unit #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .N_REGS  (N_REGS),
    .NB_BYTE (NB_BYTE)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  // Register file model with one-cycle registered read.
  always @(posedge clk) i_rd_data <= regs[o_rd_addr];
  always @(posedge clk) cyc <= cyc + 1;

  // Observe the stream mid-cycle, ahead of the edge that completes each handshake.
  always @(negedge clk) begin
    if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
    if (o_busy && !o_tx_valid && !o_done) addr_q.push_back(int'(o_rd_addr));
    if (o_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (prev_busy && !o_busy) busy_fall_cyc = cyc;
    prev_busy = o_busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    addr_q.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    busy_fall_cyc = -1;
  endtask

  // mode 0: ready always high; 1: ready held low for the first 5 valid cycles; 2: random ready.
  task automatic run_dump(input int mode, input int restart_at, output int c0);
    int held;
    held = 0;
    clear_mon();
    i_tx_ready = (mode == 0);
    i_start = 1'b1;
    c0 = cyc;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      if (restart_at > 0) i_start = ((cyc - c0) == restart_at);
      if (mode == 1) begin
        if (o_tx_valid && held < 5) begin
          chk("hold_valid", 32'(o_tx_valid), 32'd1);
          chk("hold_data", 32'(o_tx_data), 32'hA0);
          held++;
          i_tx_ready = 1'b0;
        end else begin
          i_tx_ready = 1'b1;
        end
      end else if (mode == 2) begin
        i_tx_ready = 1'($urandom_range(0, 1));
      end
      step();
    end
    i_start = 1'b0;
    chk("dump_timeout", 32'(done_cnt > 0), 32'd1);
    i_tx_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic verify_full(input string tag);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(N_REGS * BPW));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_naddr"}, 32'(addr_q.size()), 32'(2 * N_REGS));
    for (int i = 0; i < addr_q.size() && i < 2 * N_REGS; i++)
      chk({tag, "_addr"}, 32'(addr_q[i]), 32'(i / 2));
    chk({tag, "_ndone"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < N_REGS; i++) regs[i] = 32'hA000_0000 | 32'(i);
    for (int r = 0; r < N_REGS; r++)
      for (int b = BPW - 1; b >= 0; b--) exp_q.push_back(regs[r][b*8 +: 8]);

    // Reset state
    repeat (3) step();
    chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    i_rst_n = 1'b1;
    step();

    // Abort beats start in IDLE
    i_start = 1'b1;
    i_abort = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("abort_start_busy", 32'(o_busy), 32'd0);
    step();
    chk("abort_start_busy2", 32'(o_busy), 32'd0);

    // Full dump, ready always high
    run_dump(0, 0, c0);
    verify_full("s1");
    chk("s1_done_cyc", 32'(done_cyc - c0), 32'd193);
    chk("s1_busy_fall", 32'(busy_fall_cyc - c0), 32'd194);

    // Back-pressure on the first byte
    run_dump(1, 0, c0);
    verify_full("s2");

    // Start pulse while busy must be ignored
    run_dump(0, 50, c0);
    verify_full("s3");
    chk("s3_done_cyc", 32'(done_cyc - c0), 32'd193);
    chk("s3_busy_fall", 32'(busy_fall_cyc - c0), 32'd194);

    // Abort after the 2nd byte of word 3; the byte accepted with the abort counts
    clear_mon();
    i_tx_ready = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 500 && got_q.size() < 3 * BPW + 2; k++) step();
    chk("s4_reach_timeout", 32'(got_q.size()), 32'(3 * BPW + 2));
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("s4_valid", 32'(o_tx_valid), 32'd0);
    chk("s4_busy", 32'(o_busy), 32'd0);
    chk("s4_done", 32'(o_done), 32'd0);
    repeat (5) step();
    chk("s4_ndone", 32'(done_cnt), 32'd0);
    chk("s4_nbytes", 32'(got_q.size()), 32'(3 * BPW + 3));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("s4_byte", 32'(got_q[i]), 32'(exp_q[i]));
    run_dump(0, 0, c0);
    verify_full("s4_restart");

    // Asynchronous reset in the middle of word 10
    clear_mon();
    i_tx_ready = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 500 && got_q.size() < 10 * BPW + 1; k++) step();
    chk("s5_reach_timeout", 32'(got_q.size()), 32'(10 * BPW + 1));
    i_rst_n = 1'b0;
    #1;
    chk("s5_rd_addr", 32'(o_rd_addr), 32'd0);
    chk("s5_tx_data", 32'(o_tx_data), 32'd0);
    chk("s5_tx_valid", 32'(o_tx_valid), 32'd0);
    chk("s5_busy", 32'(o_busy), 32'd0);
    chk("s5_done", 32'(o_done), 32'd0);
    repeat (3) step();
    chk("s5_ndone", 32'(done_cnt), 32'd0);
    i_rst_n = 1'b1;
    step();
    run_dump(0, 0, c0);
    verify_full("s5_after");
    chk("s5_done_cyc", 32'(done_cyc - c0), 32'd193);

    // Random back-pressure
    run_dump(2, 0, c0);
    repeat (10) step();
    verify_full("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
- Debug-side reader of the CPU register file.
- On a start pulse it walks register addresses 0..N_REGS-1 and drives the address onto the register file read port.
- It waits out the register file's one-cycle registered read latency and captures each word.
- It serializes each word MSB-byte-first onto a byte stream with valid/ready handshake toward the UART transmitter.
- Used by the debug unit while the pipeline is halted.

Parameters:
- NB_DATA, 32, register width in bits; must be a multiple of NB_BYTE.
- NB_ADDR, 5, register address width.
- N_REGS, 32, number of registers dumped; must be ≤ 2**NB_ADDR.
- NB_BYTE, 8, output byte width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle request to begin a dump; ignored unless idle.
- i_abort  input  1  synchronous abort; returns to idle next cycle, no o_done.
- o_rd_addr  output  NB_ADDR  register file read address.
- i_rd_data  input  NB_DATA  register file read data, registered one cycle after the address.
- o_tx_data  output  NB_BYTE  byte to transmit.
- o_tx_valid  output  1  o_tx_data is valid.
- i_tx_ready  input  1  sink accepts the byte this cycle.
- o_busy  output  1  high in every non-IDLE state.
- o_done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset is asynchronous, active-low, clock clk. Under reset: state=IDLE, index=0, o_rd_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, shift register=0.
- Reset asserted mid-dump: immediate return to IDLE. No partial byte is held; no o_done.
- FSM states: IDLE, ADDR, LATCH, SEND, DONE.
- IDLE: o_rd_addr=0. If i_start is sampled high: index←0, go to ADDR.
- ADDR (1 cycle): o_rd_addr=index. The register file samples the address at the posedge ending this cycle.
- LATCH (1 cycle): o_rd_addr holds index. i_rd_data is valid. At the posedge ending this cycle: shift register←i_rd_data, byte counter←0, go to SEND.
- SEND:
  - o_tx_valid=1; o_tx_data=shift register [NB_DATA-1 -: NB_BYTE].
  - o_tx_data and o_tx_valid stay stable until i_tx_ready is sampled high.
  - On acceptance: shift left by NB_BYTE, increment byte counter.
  - Back-to-back bytes with no valid gap while i_tx_ready stays high.
  - After byte NB_DATA/NB_BYTE-1 is accepted:
    - index==N_REGS-1: go to DONE.
    - otherwise: index←index+1, go to ADDR. o_tx_valid drops during ADDR/LATCH.
- DONE (1 cycle): o_done=1, o_busy=1, then go to IDLE.
- Latency, i_start sampled at cycle 0 with ready always high:
  - Word k occupies cycles 1+6k..6+6k (ADDR, LATCH, 4 SEND).
  - DONE at cycle 6·N_REGS+1 (193 for defaults); o_busy low from cycle 194.
- i_start while busy: ignored, no restart.
- i_abort: priority over everything except reset. From any non-IDLE state: next state IDLE, o_tx_valid=0 next cycle, no o_done. A byte accepted in the same cycle as the abort counts as sent.
- i_abort and i_start together in IDLE: abort wins; remain IDLE.
- The index counter does not wrap past N_REGS-1.
- The block never writes the register file.

Decomposition:
- Shared package (dump_pkg):
  - FSM state encodings.
  - BYTES_PER_WORD = NB_DATA/NB_BYTE.
  - Width of the byte counter, $clog2(BYTES_PER_WORD).
- One natural sub-module: word_byte_serializer. It holds the load/shift register, byte counter and valid/ready handshake, and reports "last byte accepted". The top FSM owns index, addressing and done.

Test Plan:
- Preload reg[i]=0xA000_0000|i, ready always high, pulse i_start:
  - 128 bytes A0 00 00 00, A0 00 00 01 … A0 00 00 1F.
  - o_rd_addr steps 0..31.
  - o_done at cycle 193, o_busy low at 194.
- Hold i_tx_ready low 5 cycles on the first byte: o_tx_data=0xA0 and o_tx_valid stay stable all 5 cycles; no byte lost or duplicated; total still 128 bytes.
- Pulse i_start again at cycle 50 of a dump: byte stream and o_done timing are identical to the first scenario.
- Assert i_abort after the 2nd byte of word 3: o_tx_valid=0 next cycle, o_busy=0, no o_done. A new i_start restarts from address 0 with byte A0.
- Drop i_rst_n mid-SEND of word 10: all outputs 0 immediately. After release plus i_start, a full 128-byte dump completes correctly.
- Random i_tx_ready toggling (50%): byte sequence matches the reference model and o_done fires exactly once.
